// File: rtl/femto_ahb_master.sv
// femto_ahb_master: FemtoRV32 memory port to single-transfer AHB-Lite master.
// Define AHB_MASTER_TIMEOUT_EN to abort data phases stalled for TIMEOUT_CYCLES.
module femto_ahb_master #(
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_rbusy,
  output logic        mem_wbusy,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        bus_error
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state;
  logic [2:0] size;
  logic [1:0] lo;
  logic req;
`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
`endif
  assign req = mem_rstrb || |mem_wmask;
  assign mem_rbusy = state != IDLE && !HWRITE;
  assign mem_wbusy = state != IDLE && HWRITE;
  // Reads and irregular masks fall through to a word transfer.
  always_comb begin
    size = 3'b010;
    lo = 2'b00;
    case (mem_wmask)
      4'b0011: size = 3'b001;
      4'b1100: begin size = 3'b001; lo = 2'b10; end
      4'b0001: size = 3'b000;
      4'b0010: begin size = 3'b000; lo = 2'b01; end
      4'b0100: begin size = 3'b000; lo = 2'b10; end
      4'b1000: begin size = 3'b000; lo = 2'b11; end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      HTRANS <= 2'b00;
      HADDR <= '0;
      HWRITE <= 1'b0;
      HSIZE <= 3'b010;
      HWDATA <= '0;
      mem_rdata <= '0;
      bus_error <= 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
      cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req) begin
          state <= ADDR;
          HTRANS <= 2'b10;
          HADDR <= {mem_addr[31:2], lo};
          HSIZE <= size;
          HWRITE <= |mem_wmask;
          if (|mem_wmask) HWDATA <= mem_wdata;
        end
        ADDR: if (HREADY) begin
          state <= DATA;
          HTRANS <= 2'b00;
`ifdef AHB_MASTER_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        DATA: begin
          if (HRESP) bus_error <= 1'b1;
          if (HREADY) begin
            state <= IDLE;
            if (!HWRITE) mem_rdata <= HRESP ? ERR_DATA : HRDATA;
          end
`ifdef AHB_MASTER_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state <= IDLE;
            bus_error <= 1'b1;
            if (!HWRITE) mem_rdata <= ERR_DATA;
          end else cnt <= cnt + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_femto_ahb_master.sv
// tb_femto_ahb_master: directed and random checks against a transaction-level model.
module tb_femto_ahb_master;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam int TO = 16;
  logic clk = 0, reset = 1;
  logic [31:0] mem_addr = 0, mem_wdata = 0, mem_rdata, HADDR, HWDATA, HRDATA = 0;
  logic [3:0] mem_wmask = 0;
  logic mem_rstrb = 0, mem_rbusy, mem_wbusy, HWRITE, HREADY = 1, HRESP = 0, bus_error;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  femto_ahb_master dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .bus_error(bus_error)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  // Transaction-level model: one outstanding transfer, address phase then data phase.
  bit m_busy, m_aph, m_wr, m_berr;
  logic [31:0] m_haddr, m_hwdata, m_rdata;
  logic [2:0] m_hsize;
  int m_cnt;
  function automatic void decode(input logic [31:0] a, input logic [3:0] m,
                                 output logic [31:0] ha, output logic [2:0] hs);
    logic [1:0] lo;
    case (m)
      4'b0011: begin hs = 1; lo = 0; end
      4'b1100: begin hs = 1; lo = 2; end
      4'b0001: begin hs = 0; lo = 0; end
      4'b0010: begin hs = 0; lo = 1; end
      4'b0100: begin hs = 0; lo = 2; end
      4'b1000: begin hs = 0; lo = 3; end
      default: begin hs = 2; lo = 0; end
    endcase
    ha = {a[31:2], lo};
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_aph = 0; m_wr = 0; m_berr = 0; m_rdata = 0;
    end else if (!m_busy) begin
      if (mem_rstrb || mem_wmask != 0) begin
        m_busy = 1; m_aph = 1; m_wr = mem_wmask != 0;
        decode(mem_addr, mem_wmask, m_haddr, m_hsize);
        if (m_wr) m_hwdata = mem_wdata;
      end
    end else if (m_aph) begin
      if (HREADY) begin m_aph = 0; m_cnt = 0; end
    end else begin
      if (HRESP) m_berr = 1;
      if (HREADY) begin
        m_busy = 0;
        if (!m_wr) m_rdata = HRESP ? ERR : HRDATA;
      end
`ifdef AHB_MASTER_TIMEOUT_EN
      else begin
        m_cnt++;
        if (m_cnt == TO) begin
          m_busy = 0; m_berr = 1;
          if (!m_wr) m_rdata = ERR;
        end
      end
`endif
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("htrans", 32'(HTRANS), (m_busy && m_aph) ? 32'd2 : 32'd0);
    chk("rbusy", 32'(mem_rbusy), 32'(m_busy && !m_wr));
    chk("wbusy", 32'(mem_wbusy), 32'(m_busy && m_wr));
    chk("rdata", mem_rdata, m_rdata);
    chk("bus_error", 32'(bus_error), 32'(m_berr));
    if (m_busy && m_aph) begin
      chk("haddr", HADDR, m_haddr);
      chk("hsize", 32'(HSIZE), 32'(m_hsize));
      chk("hwrite", 32'(HWRITE), 32'(m_wr));
    end
    if (m_busy && !m_aph && m_wr) chk("hwdata", HWDATA, m_hwdata);
  end
  task automatic cyc(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    cyc(3);
    chk("rst_htrans", 32'(HTRANS), 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hsize", 32'(HSIZE), 2);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_busy", 32'({mem_rbusy, mem_wbusy, bus_error, HWRITE}), 0);
    reset = 0;
    chk_en = 1;
    // Reset while a read stalls in its data phase.
    mem_rstrb = 1; mem_addr = 32'h40; HRDATA = 32'hCAFE_F00D; HREADY = 1;
    cyc(); mem_rstrb = 0;
    cyc(); HREADY = 0;
    cyc(); chk("mid_rbusy_before", 32'(mem_rbusy), 1); reset = 1;
    cyc(); chk("mid_htrans", 32'(HTRANS), 0); chk("mid_rbusy", 32'(mem_rbusy), 0);
    chk("mid_rdata", mem_rdata, 0);
    reset = 0; HREADY = 1;
    cyc();
    // Zero-wait word read.
    mem_rstrb = 1; mem_addr = 32'h1000_0007; HRDATA = 32'h1234_5678;
    cyc(); chk("rd_htrans", 32'(HTRANS), 2); chk("rd_haddr", HADDR, 32'h1000_0004);
    chk("rd_hsize", 32'(HSIZE), 2); chk("rd_rbusy1", 32'(mem_rbusy), 1); mem_rstrb = 0;
    cyc(); chk("rd_rbusy2", 32'(mem_rbusy), 1); chk("rd_htrans2", 32'(HTRANS), 0);
    cyc(); chk("rd_rbusy3", 32'(mem_rbusy), 0); chk("rd_data", mem_rdata, 32'h1234_5678);
    // Read with two data-phase wait states.
    mem_rstrb = 1; mem_addr = 32'h2000_0000; HRDATA = 32'h0BAD_CAFE;
    cyc(); mem_rstrb = 0;
    cyc(); HREADY = 0;
    cyc(); chk("ws_rbusy3", 32'(mem_rbusy), 1);
    cyc(); chk("ws_rbusy4", 32'(mem_rbusy), 1); HREADY = 1;
    cyc(); chk("ws_rbusy5", 32'(mem_rbusy), 0); chk("ws_data", mem_rdata, 32'h0BAD_CAFE);
    // Byte write on lane 2.
    mem_wmask = 4'b0100; mem_addr = 32'h2001; mem_wdata = 32'h00AB_0000;
    cyc(); chk("wr_haddr", HADDR, 32'h2002); chk("wr_hsize", 32'(HSIZE), 0);
    chk("wr_hwrite", 32'(HWRITE), 1); chk("wr_wbusy1", 32'(mem_wbusy), 1); mem_wmask = 0;
    cyc(); chk("wr_hwdata", HWDATA, 32'h00AB_0000);
    cyc(); chk("wr_wbusy3", 32'(mem_wbusy), 0);
    // Two-cycle error response on a read.
    mem_rstrb = 1; mem_addr = 32'h30;
    cyc(); mem_rstrb = 0;
    cyc(); HREADY = 0; HRESP = 1;
    cyc(); chk("er_berr", 32'(bus_error), 1); chk("er_rbusy", 32'(mem_rbusy), 1); HREADY = 1;
    cyc(); chk("er_data", mem_rdata, ERR); chk("er_rbusy2", 32'(mem_rbusy), 0); HRESP = 0;
    mem_rstrb = 1; mem_addr = 32'h50; HRDATA = 32'h11;
    cyc(); mem_rstrb = 0;
    cyc(2); chk("er_good_data", mem_rdata, 32'h11); chk("er_sticky", 32'(bus_error), 1);
`ifdef AHB_MASTER_TIMEOUT_EN
    reset = 1; cyc(); reset = 0;
    mem_rstrb = 1; mem_addr = 32'h60;
    cyc(); mem_rstrb = 0;
    cyc(); HREADY = 0;
    cyc(15); chk("to_rbusy", 32'(mem_rbusy), 1);
    cyc(); chk("to_done", 32'(mem_rbusy), 0); chk("to_data", mem_rdata, ERR);
    chk("to_berr", 32'(bus_error), 1); HREADY = 1;
`endif
    // Random traffic, including occasional resets and collisions.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 200) == 0;
      mem_rstrb = ($urandom % 4) == 0;
      mem_wmask = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
      mem_addr = $urandom; mem_wdata = $urandom; HRDATA = $urandom;
      HREADY = ($urandom % 3) != 0;
      HRESP = ($urandom % 10) == 0;
      cyc();
    end
    reset = 0; mem_rstrb = 0; mem_wmask = 0;
    cyc(2);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
